// File: rtl/eth_tx_sched.sv
// eth_tx_sched: two-source Ethernet frame scheduler.
//   Picks a byte FIFO whose fill level covers one full frame (round-robin when
//   both qualify), emits one Ethernet header, then passes exactly FRAME_LEN
//   payload bytes from that FIFO to an AXI-Stream output, tagging the final
//   byte with tlast.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sN_tdata/tvalid/tready   byte-FIFO read side, source N (N=0,1)
//   sN_level                 FIFO fill level, source N
//   m_eth_hdr_*              header handshake plus dest/src MAC and EtherType
//   m_eth_payload_axis_*     payload stream (tuser tied low)
//   grant                    one-hot active source
//   busy                     high while a frame is in progress
//   frame_cnt                completed frames, wrapping
module eth_tx_sched #(
  parameter int unsigned FRAME_LEN = 512,
  parameter logic [47:0] DEST_MAC  = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] TYPE0     = 16'h88B5,
  parameter logic [15:0] TYPE1     = 16'h88B6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [15:0] s0_level,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic [15:0] s1_level,
  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [7:0]  m_eth_payload_axis_tdata,
  output logic        m_eth_payload_axis_tvalid,
  input  logic        m_eth_payload_axis_tready,
  output logic        m_eth_payload_axis_tlast,
  output logic        m_eth_payload_axis_tuser,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam logic [15:0] FLEN     = 16'(FRAME_LEN);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        prio_q, prio_d;       // 1: source 1 wins a tie
  logic        hdr_valid_q, hdr_valid_d;
  logic [47:0] dest_q, dest_d, src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic in_pay, beat, elig0, elig1, pick1;

  // Gating with rst keeps the FIFOs from being popped in a reset cycle.
  assign in_pay = (state_q == PAYLOAD) && !rst;

  always_comb begin
    m_eth_payload_axis_tdata  = 8'h00;
    m_eth_payload_axis_tvalid = 1'b0;
    s0_tready                 = 1'b0;
    s1_tready                 = 1'b0;
    if (in_pay) begin
      if (grant_q[1]) begin
        m_eth_payload_axis_tdata  = s1_tdata;
        m_eth_payload_axis_tvalid = s1_tvalid;
        s1_tready                 = m_eth_payload_axis_tready;
      end else begin
        m_eth_payload_axis_tdata  = s0_tdata;
        m_eth_payload_axis_tvalid = s0_tvalid;
        s0_tready                 = m_eth_payload_axis_tready;
      end
    end
  end

  assign m_eth_payload_axis_tlast = in_pay && (cnt_q == LAST_IDX);
  assign m_eth_payload_axis_tuser = 1'b0;
  assign beat  = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;

  assign elig0 = (s0_level >= FLEN);
  assign elig1 = (s1_level >= FLEN);
  assign pick1 = elig1 && (!elig0 || prio_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    hdr_valid_d = hdr_valid_q;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          grant_d     = pick1 ? 2'b10 : 2'b01;
          type_d      = pick1 ? TYPE1 : TYPE0;
          dest_d      = DEST_MAC;
          src_d       = SRC_MAC;
          hdr_valid_d = 1'b1;
          prio_d      = !pick1;      // the other source wins the next tie
          state_d     = HDR;
        end
      end
      HDR: begin
        if (m_eth_hdr_ready) begin
          hdr_valid_d = 1'b0;
          cnt_d       = 16'd0;
          state_d     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (beat) begin
          cnt_d = cnt_q + 16'd1;
          if (m_eth_payload_axis_tlast) begin
            state_d     = IDLE;
            grant_d     = 2'b00;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      prio_q      <= 1'b0;
      hdr_valid_q <= 1'b0;
      dest_q      <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      cnt_q       <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      hdr_valid_q <= hdr_valid_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_eth_hdr_valid = hdr_valid_q;
  assign m_eth_dest_mac  = dest_q;
  assign m_eth_src_mac   = src_q;
  assign m_eth_type      = type_q;
  assign grant           = grant_q;
  assign busy            = (state_q != IDLE);
  assign frame_cnt       = frame_cnt_q;
endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched with default parameters (512-byte frames).
// Time phases: inputs change at negedge+1, outputs are sampled at negedge+2
// (or negedge+1 when no input changed), well away from the rising edge.
module tb_eth_tx_sched;
  localparam int FL = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s0_tdata, s1_tdata;
  logic        s0_tvalid, s1_tvalid, s0_tready, s1_tready;
  logic [15:0] s0_level, s1_level;
  logic        m_eth_hdr_valid, m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_chk = 0;
  int n_err = 0;
  int ptr[2];
  int exp_frames;

  always #5 clk = ~clk;

  eth_tx_sched dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_level(s0_level),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_level(s1_level),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tvalid(m_tvalid),
    .m_eth_payload_axis_tready(m_tready), .m_eth_payload_axis_tlast(m_tlast),
    .m_eth_payload_axis_tuser(m_tuser),
    .grant(grant), .busy(busy), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Distinct byte streams per source so a wrong mux or reordering shows up.
  function automatic logic [7:0] dat(input int src, input int p);
    logic [7:0] b;
    b = 8'(p ^ (p >> 8));
    return (src == 1) ? (b ^ 8'h5A) : b;
  endfunction

  task automatic drive_data();
    s0_tdata = dat(0, ptr[0]);
    s1_tdata = dat(1, ptr[1]);
  endtask

  // Leaves time at negedge+1 with rst released.
  task automatic do_reset();
    rst = 1'b1;
    s0_level = 16'd0; s1_level = 16'd0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    m_tready = 1'b0; m_eth_hdr_ready = 1'b0;
    drive_data();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_grant"}, 64'(grant), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_hdr_valid"}, 64'(m_eth_hdr_valid), 64'd0);
    chk({pfx, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({pfx, "_tlast"}, 64'(m_tlast), 64'd0);
    chk({pfx, "_sready"}, 64'({s0_tready, s1_tready}), 64'd0);
    chk({pfx, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    chk({pfx, "_hdr_fields"}, 64'({m_eth_type, m_eth_src_mac[15:0], m_eth_dest_mac[15:0]}), 64'd0);
  endtask

  // One frame from source src. hdr_wait: cycles hdr_ready held low.
  // tog: m_tready toggles; gaps: source tvalid drops every third cycle.
  // stop_at < FL abandons the frame after that many accepted beats.
  task automatic do_frame(input int src, input int hdr_wait, input bit tog,
                          input bit gaps, input int stop_at);
    int n, vcyc, fld_bad, hdr_pay_bad, beats, cyc, start, last_idx;
    int data_bad, other_bad, tlast_bad, tuser_bad;
    logic [47:0] d0, s0m;
    logic [15:0] t0;
    bit done;
    logic tv;
    n = 0;
    while (!m_eth_hdr_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("hdr_seen", 64'(m_eth_hdr_valid), 64'd1);
    chk("grant", 64'(grant), (src == 1) ? 64'd2 : 64'd1);
    chk("eth_type", 64'(m_eth_type), (src == 1) ? 64'h88B6 : 64'h88B5);
    chk("dest_mac", 64'(m_eth_dest_mac), 64'hFFFF_FFFF_FFFF);
    chk("src_mac", 64'(m_eth_src_mac), 64'h0200_0000_0001);
    chk("busy_hdr", 64'(busy), 64'd1);
    d0 = m_eth_dest_mac; s0m = m_eth_src_mac; t0 = m_eth_type;
    vcyc = 0; fld_bad = 0; hdr_pay_bad = 0;
    while (m_eth_hdr_valid && vcyc < 50) begin
      vcyc++;
      if (m_eth_dest_mac !== d0 || m_eth_src_mac !== s0m || m_eth_type !== t0) fld_bad++;
      if (m_tvalid || s0_tready || s1_tready) hdr_pay_bad++;
      m_eth_hdr_ready = (vcyc > hdr_wait);
      @(negedge clk); #1;
    end
    m_eth_hdr_ready = 1'b0;
    chk("hdr_valid_cycles", 64'(vcyc), 64'(hdr_wait + 1));
    chk("hdr_fields_stable", 64'(fld_bad), 64'd0);
    chk("no_payload_in_hdr", 64'(hdr_pay_bad), 64'd0);

    beats = 0; cyc = 0; start = ptr[src]; last_idx = -1; done = 1'b0;
    data_bad = 0; other_bad = 0; tlast_bad = 0; tuser_bad = 0;
    while (!done && beats < stop_at && cyc < 4000) begin
      m_tready = tog ? cyc[0] : 1'b1;
      tv = gaps ? ((cyc % 3) != 2) : 1'b1;
      // the idle source always offers data to expose a leaky ready
      s0_tvalid = (src == 0) ? tv : 1'b1;
      s1_tvalid = (src == 1) ? tv : 1'b1;
      drive_data();
      #1;
      if (m_tuser !== 1'b0) tuser_bad++;
      if ((src == 0 && s1_tready) || (src == 1 && s0_tready)) other_bad++;
      if (m_tvalid && m_tready) begin
        if (m_tdata !== dat(src, start + beats)) data_bad++;
        if (m_tlast !== (beats == FL - 1)) tlast_bad++;
        if (m_tlast) begin last_idx = beats; done = 1'b1; end
        beats++;
      end
      if (s0_tready && s0_tvalid) ptr[0]++;
      if (s1_tready && s1_tvalid) ptr[1]++;
      @(negedge clk); #1;
      cyc++;
    end
    chk("data_order", 64'(data_bad), 64'd0);
    chk("idle_src_ready", 64'(other_bad), 64'd0);
    chk("tlast_pos_err", 64'(tlast_bad), 64'd0);
    chk("tuser_zero", 64'(tuser_bad), 64'd0);
    if (stop_at >= FL) begin
      exp_frames++;
      chk("beats", 64'(beats), 64'(FL));
      chk("tlast_idx", 64'(last_idx), 64'(FL - 1));
      chk("consumed", 64'(ptr[src] - start), 64'(FL));
      chk("busy_after", 64'(busy), 64'd0);
      chk("grant_after", 64'(grant), 64'd0);
      chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    end else begin
      chk("partial_beats", 64'(beats), 64'(stop_at));
    end
  endtask

  initial begin
    ptr[0] = 0; ptr[1] = 0; exp_frames = 0;
    rst = 1'b1;
    do_reset();
    chk_reset_vals("rst");

    // Level threshold: 511 is not enough, 512 grants on the next cycle.
    s0_level = 16'd511;
    @(negedge clk); @(negedge clk); #1;
    chk("lvl511_grant", 64'(grant), 64'd0);
    chk("lvl511_busy", 64'(busy), 64'd0);
    s0_level = 16'd512;
    @(negedge clk); #1;
    chk("lvl512_grant", 64'(grant), 64'd1);
    chk("lvl512_hdr_valid", 64'(m_eth_hdr_valid), 64'd1);
    do_frame(0, 0, 1'b0, 1'b0, FL);

    // Both sources full: strict alternation starting with source 0.
    do_reset();
    s0_level = 16'd1024; s1_level = 16'd1024;
    do_frame(0, 0, 1'b0, 1'b0, FL);
    do_frame(1, 0, 1'b0, 1'b0, FL);
    do_frame(0, 0, 1'b0, 1'b0, FL);
    do_frame(1, 0, 1'b0, 1'b0, FL);

    // Header back-pressure for five cycles.
    do_reset();
    s0_level = 16'd512;
    do_frame(0, 5, 1'b0, 1'b0, FL);

    // Source 1 with output back-pressure and input gaps.
    do_reset();
    s1_level = 16'd512;
    do_frame(1, 0, 1'b1, 1'b1, FL);

    // Reset after 100 beats, then a clean frame.
    do_reset();
    s0_level = 16'd512;
    do_frame(0, 0, 1'b0, 1'b0, 100);
    rst = 1'b1;
    #1;
    chk("rst_no_consume", 64'(s0_tready), 64'd0);
    chk("rst_no_tvalid", 64'(m_tvalid), 64'd0);
    @(negedge clk); #1;
    chk_reset_vals("midrst");
    rst = 1'b0;
    exp_frames = 0;
    do_frame(0, 0, 1'b0, 1'b0, FL);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
